pipe_stage_buffer: RTL and testbench
====================================

// Module: pipe_stage_buffer
// PURPOSE
//  Parametrised pipeline stage register for the ID/EX (and later EX/MEM, MEM/WB) boundaries.
//  Carries one datapath bundle and one control bundle under valid/ready handshakes.
//  Adds stall back-pressure, synchronous flush with bubble insertion, and an optional
//  2-entry skid buffer so that in_ready is registered while throughput stays at 1/clk.
// PARAMETERS
//  DATA_W       165    datapath bundle width (pc, pcInc, rs1, rs2, imm = 5x32, plus rd = 5)
//  CTRL_W       17     control bundle width (RUWr, DMWr, ALUASrc, ALUBSrc, RUDataWrSrc, DMCtrl, AluOp, BrOp)
//  CTRL_BUBBLE  '0     control value for an empty slot (NOP: no RF or DM write)
//  SKID         1      1 = 2-entry skid, in_ready registered; 0 = single entry, in_ready combinational
//  CNT_W        16     stall counter width
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous reset, active low
//  flush      in   1       synchronous kill of all held entries (branch or jump redirect)
//  in_valid   in   1       upstream bundle valid
//  in_ready   out  1       stage can accept this cycle
//  in_data    in   DATA_W  upstream datapath bundle
//  in_ctrl    in   CTRL_W  upstream control bundle
//  out_valid  out  1       head entry valid
//  out_ready  in   1       downstream accepts the head entry
//  out_data   out  DATA_W  head datapath bundle
//  out_ctrl   out  CTRL_W  head control bundle; CTRL_BUBBLE whenever out_valid=0
//  occupancy  out  2       number of valid entries (0..2; max 1 when SKID=0)
//  stall_cnt  out  CNT_W   cycles with out_valid & !out_ready; saturating
// BEHAVIOUR
//  - Storage: main slot M (drives out_*) and skid slot S (SKID=1 only).
//    accept = in_valid & in_ready & !flush. pop = out_valid & out_ready.
//  - Reset (rst_n=0, async): M and S invalid; out_valid=0, in_ready=0 while asserted,
//    then 1 on the first cycle after release. out_ctrl=CTRL_BUBBLE, out_data=0,
//    occupancy=0, stall_cnt=0.
//  - Latency: 1 clk. A bundle accepted at edge N is visible at out_* after edge N.
//  - SKID=1 states:
//    EMPTY: accept -> ONE (M<=in).
//    ONE:   accept&pop -> ONE (M<=in); accept&!pop -> TWO (S<=in);
//           !accept&pop -> EMPTY; otherwise hold.
//    TWO:   pop -> ONE (M<=S, S invalid); otherwise hold. No accept is possible in TWO.
//    in_ready = !S_valid & !flush. in_ready has no combinational path from out_ready.
//  - SKID=0: in_ready = (!M_valid | out_ready) & !flush. accept loads M; pop without accept empties M.
//  - Ordering: strict FIFO; no bundle is dropped or duplicated, except by flush.
//  - Flush (sync, highest priority): at the next edge M and S are invalid and in_data is not captured.
//    A pop in the flush cycle still completes downstream. Flush has priority over a simultaneous accept.
//  - Empty slot: every transition that leaves M invalid loads M_ctrl <= CTRL_BUBBLE. M_data holds its last value.
//  - Hold: with no accept and no pop, all outputs are stable (stall preserves the bundle bit-exact).
//  - stall_cnt: +1 each cycle out_valid & !out_ready. Saturates at 2^CNT_W-1, no wrap. Cleared only by reset.
//  - Reset mid-operation drops all entries immediately; no partial bundle appears after release.
// TESTING
//  1 Stream, out_ready=1: in_valid=1 for 8 cycles, in_data=1..8
//    -> out_data 1..8 one cycle later, occupancy=1, in_ready never low.
//  2 Back-pressure, SKID=1: send A,B,C with out_ready=0
//    -> A in M, B in S, in_ready=0 at occupancy 2, C held upstream.
//    Then out_ready=1 -> out A,B,C in order.
//  3 Flush with occupancy 2 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, input not captured.
//  4 Stall 5 cycles with head AluOp=4'h3 -> out_* unchanged, stall_cnt=5.
//    CNT_W=3 with 10 stall cycles -> stall_cnt=7.
//  5 Assert rst_n=0 mid-stream with occupancy 2 -> out_valid=0 asynchronously.
//    After release: in_ready=1, no stale bundle emitted.
//  6 SKID=0: out_ready=0 with M full -> in_ready=0. out_ready=1 with in_valid=1 -> pass-through at 1/clk.

Source files
------------

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: valid/ready pipeline register with stall counting,
// synchronous flush with bubble insertion and an optional 2-entry skid
// buffer that keeps in_ready registered while sustaining one bundle per clock.
module pipe_stage_buffer #(
  parameter int                DATA_W      = 165,
  parameter int                CTRL_W      = 17,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                SKID        = 1,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The state value is the number of valid entries, so it doubles as occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_reg;
  logic [DATA_W-1:0]   m_data_reg;
  logic [CTRL_W-1:0]   m_ctrl_reg;
  logic [DATA_W-1:0]   s_data_reg;
  logic [CTRL_W-1:0]   s_ctrl_reg;
  logic                live_reg;
  logic [CNT_W-1:0]    stall_cnt_reg;

  logic                m_valid;
  logic                s_valid;
  logic                accept;
  logic                pop;

  assign m_valid = (state_reg != EMPTY);
  assign s_valid = (state_reg == TWO);

  // With a skid slot, in_ready depends only on registered state (plus flush),
  // so out_ready never reaches in_ready combinationally. Without it, a full
  // main slot can still accept when the head leaves in the same cycle.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = live_reg & ~s_valid & ~flush;
    end else begin : g_single
      assign in_ready = live_reg & (~m_valid | out_ready) & ~flush;
    end
  endgenerate

  // in_ready already excludes flush, so accept can never fire during a flush.
  assign accept = in_valid & in_ready;
  assign pop    = m_valid & out_ready;

  assign out_valid = m_valid;
  assign out_data  = m_data_reg;
  assign out_ctrl  = m_ctrl_reg;
  assign occupancy = state_reg;
  assign stall_cnt = stall_cnt_reg;

  // Holds in_ready low through reset and for the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_reg <= 1'b0;
    end else begin
      live_reg <= 1'b1;
    end
  end

  // Slot occupancy FSM: moves bundles into M/S and empties them on pop or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= EMPTY;
      m_data_reg <= '0;
      m_ctrl_reg <= CTRL_BUBBLE;
      s_data_reg <= '0;
      s_ctrl_reg <= CTRL_BUBBLE;
    end else if (flush) begin
      // Kill everything; M_data keeps its stale value but ctrl becomes a NOP.
      state_reg  <= EMPTY;
      m_ctrl_reg <= CTRL_BUBBLE;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            m_data_reg <= in_data;
            m_ctrl_reg <= in_ctrl;
            state_reg  <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            m_data_reg <= in_data;
            m_ctrl_reg <= in_ctrl;
          end else if (accept && (SKID != 0)) begin
            // Head is stalled: park the new bundle behind it.
            s_data_reg <= in_data;
            s_ctrl_reg <= in_ctrl;
            state_reg  <= TWO;
          end else if (pop) begin
            m_ctrl_reg <= CTRL_BUBBLE;
            state_reg  <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            m_data_reg <= s_data_reg;
            m_ctrl_reg <= s_ctrl_reg;
            state_reg  <= ONE;
          end
        end
        default: begin
          m_ctrl_reg <= CTRL_BUBBLE;
          state_reg  <= EMPTY;
        end
      endcase
    end
  end

  // Saturating count of cycles in which a valid head is held by downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (m_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Testbench for pipe_stage_buffer: scoreboard on the main (SKID=1) instance,
// plus a CNT_W=3 instance for saturation and a SKID=0 instance.
module tb_pipe_stage_buffer;

  localparam int DATA_W = 165;
  localparam int CTRL_W = 17;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_ready = 1'b0;

  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cnt;

  logic              sat_in_ready, sat_out_valid;
  logic [DATA_W-1:0] sat_out_data;
  logic [CTRL_W-1:0] sat_out_ctrl;
  logic [1:0]        sat_occupancy;
  logic [2:0]        sat_stall_cnt;

  logic              ns_in_ready, ns_out_valid;
  logic [DATA_W-1:0] ns_out_data;
  logic [CTRL_W-1:0] ns_out_ctrl;
  logic [1:0]        ns_occupancy;
  logic [15:0]       ns_stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [DATA_W+CTRL_W-1:0] sbq[$];

  always #5 clk = ~clk;

  pipe_stage_buffer #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_buffer #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data), .out_ctrl(sat_out_ctrl),
    .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt)
  );

  pipe_stage_buffer #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0), .CNT_W(16)) u_ns (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ns_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ns_out_valid), .out_ready(out_ready), .out_data(ns_out_data), .out_ctrl(ns_out_ctrl),
    .occupancy(ns_occupancy), .stall_cnt(ns_stall_cnt)
  );

  function automatic logic [DATA_W-1:0] mk_data(input int i);
    return {32'(i), 32'(i + 100), 32'(i * 3), 32'(~i), 32'(i << 4), 5'(i)};
  endfunction

  function automatic logic [CTRL_W-1:0] mk_ctrl(input int i, input logic [3:0] aluop);
    return {1'b1, 4'(i), aluop, 8'(i)};
  endfunction

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Samples the cycle just after the negedge, scores transfers, then advances one clock.
  task automatic tick();
    logic [DATA_W+CTRL_W-1:0] exp;
    #1;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_pop", 192'(out_valid), 192'(0));
      end else begin
        exp = sbq.pop_front();
        $display("t=%0t pop data=%0h ctrl=%0h", $time, out_data, out_ctrl);
        check("sb_data", 192'({out_data, out_ctrl}), 192'(exp));
      end
    end
    if (!out_valid) check("bubble_ctrl", 192'(out_ctrl), 192'(0));
    if (in_valid && in_ready && !flush) begin
      sbq.push_back({in_data, in_ctrl});
      $display("t=%0t push data=%0h ctrl=%0h", $time, in_data, in_ctrl);
    end
    if (flush) sbq.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    acc = 1'b0;

    // Reset values while rst_n is held low
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 192'(out_valid), 192'(0));
    check("rst_in_ready", 192'(in_ready), 192'(0));
    check("rst_occupancy", 192'(occupancy), 192'(0));
    check("rst_stall_cnt", 192'(stall_cnt), 192'(0));
    check("rst_out_ctrl", 192'(out_ctrl), 192'(0));
    check("rst_out_data", 192'(out_data), 192'(0));
    do_reset();
    #1 check("rst_in_ready_after", 192'(in_ready), 192'(1));
    @(negedge clk);

    // 1: streaming with out_ready=1
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = mk_data(i);
      in_ctrl = mk_ctrl(i, 4'h1);
      #1;
      check("t1_in_ready", 192'(in_ready), 192'(1));
      if (i > 1) begin
        check("t1_occupancy", 192'(occupancy), 192'(1));
        check("t1_latency", 192'(out_data), 192'(mk_data(i - 1)));
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    #1;
    check("t1_empty_occ", 192'(occupancy), 192'(0));
    check("t1_empty_valid", 192'(out_valid), 192'(0));
    @(negedge clk);

    // 2: back-pressure fills M then S; C waits upstream
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = mk_data(20); in_ctrl = mk_ctrl(20, 4'h2);
    tick();
    in_data = mk_data(21); in_ctrl = mk_ctrl(21, 4'h2);
    tick();
    in_data = mk_data(22); in_ctrl = mk_ctrl(22, 4'h2);
    #1;
    check("t2_in_ready_full", 192'(in_ready), 192'(0));
    check("t2_occupancy", 192'(occupancy), 192'(2));
    check("t2_head_a", 192'(out_data), 192'(mk_data(20)));
    tick();
    out_ready = 1'b1;
    #1 check("t2_ready_registered", 192'(in_ready), 192'(0));
    for (int k = 0; k < 10 && in_valid; k++) begin
      #1 acc = in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    check("t2_c_accepted", 192'(acc), 192'(1));
    for (int k = 0; k < 10 && sbq.size() > 0; k++) tick();
    check("t2_drained", 192'(sbq.size()), 192'(0));
    #1 check("t2_occ_zero", 192'(occupancy), 192'(0));
    @(negedge clk);

    // 3: flush at occupancy 2 with in_valid=1
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = mk_data(30); in_ctrl = mk_ctrl(30, 4'h5);
    tick();
    in_data = mk_data(31); in_ctrl = mk_ctrl(31, 4'h5);
    tick();
    in_data = mk_data(32); in_ctrl = mk_ctrl(32, 4'h5);
    flush = 1'b1;
    #1;
    check("t3_occ_before", 192'(occupancy), 192'(2));
    check("t3_in_ready_flush", 192'(in_ready), 192'(0));
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t3_out_valid", 192'(out_valid), 192'(0));
    check("t3_out_ctrl", 192'(out_ctrl), 192'(0));
    check("t3_occupancy", 192'(occupancy), 192'(0));
    tick();
    tick();
    #1 check("t3_not_captured", 192'(out_valid), 192'(0));
    do_reset();

    // 4: stall holds the head and counts; CNT_W=3 instance saturates
    in_valid = 1'b1;
    in_data = mk_data(50); in_ctrl = mk_ctrl(50, 4'h3);
    tick();
    in_valid = 1'b0;
    in_data = '0; in_ctrl = '0;
    for (int k = 0; k < 5; k++) begin
      #1 check("t4_hold", 192'({out_data, out_ctrl}), 192'({mk_data(50), mk_ctrl(50, 4'h3)}));
      tick();
    end
    #1;
    check("t4_stall5", 192'(stall_cnt), 192'(5));
    check("t4_sat_stall5", 192'(sat_stall_cnt), 192'(5));
    for (int k = 0; k < 5; k++) tick();
    #1;
    check("t4_stall10", 192'(stall_cnt), 192'(10));
    check("t4_sat_stall10", 192'(sat_stall_cnt), 192'(7));
    check("t4_hold_end", 192'({out_data, out_ctrl}), 192'({mk_data(50), mk_ctrl(50, 4'h3)}));
    out_ready = 1'b1;
    tick();
    tick();
    check("t4_drained", 192'(sbq.size()), 192'(0));

    // 5: asynchronous reset with occupancy 2
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = mk_data(60); in_ctrl = mk_ctrl(60, 4'h6);
    tick();
    in_data = mk_data(61); in_ctrl = mk_ctrl(61, 4'h6);
    tick();
    in_valid = 1'b0;
    #1 check("t5_occ_before", 192'(occupancy), 192'(2));
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 192'(out_valid), 192'(0));
    check("t5_async_occ", 192'(occupancy), 192'(0));
    check("t5_async_ready", 192'(in_ready), 192'(0));
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 check("t5_in_ready", 192'(in_ready), 192'(1));
    for (int k = 0; k < 3; k++) begin
      #1 check("t5_no_stale", 192'(out_valid), 192'(0));
      tick();
    end
    in_valid = 1'b1;
    in_data = mk_data(62); in_ctrl = mk_ctrl(62, 4'h6);
    tick();
    in_valid = 1'b0;
    tick();
    check("t5_drained", 192'(sbq.size()), 192'(0));
    do_reset();

    // 6: SKID=0 instance
    in_valid = 1'b1;
    in_data = mk_data(40); in_ctrl = mk_ctrl(40, 4'h7);
    tick();
    in_valid = 1'b0;
    #1;
    check("t6_ns_ready_full", 192'(ns_in_ready), 192'(0));
    check("t6_ns_occ", 192'(ns_occupancy), 192'(1));
    out_ready = 1'b1;
    #1 check("t6_ns_ready_comb", 192'(ns_in_ready), 192'(1));
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data = mk_data(40 + i); in_ctrl = mk_ctrl(40 + i, 4'h7);
      #1;
      check("t6_ns_in_ready", 192'(ns_in_ready), 192'(1));
      check("t6_ns_out_valid", 192'(ns_out_valid), 192'(1));
      check("t6_ns_out_data", 192'(ns_out_data), 192'(mk_data(40 + i - 1)));
      tick();
    end
    in_valid = 1'b0;
    #1 check("t6_ns_last", 192'(ns_out_data), 192'(mk_data(44)));
    tick();
    #1;
    check("t6_ns_empty", 192'(ns_out_valid), 192'(0));
    check("t6_drained", 192'(sbq.size()), 192'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
